// File: rtl/map_pkg.sv
// map_pkg: shared widths and FSM state type for the map write arbiter.
package map_pkg;
  localparam int MAP_ADDR_W = 15;
  localparam int BLOCK_ID_W = 5;
  typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin selector; ptr names the index favoured on a tie.
module rr_arb2 (
  input  logic [1:0] elig,
  input  logic       ptr,
  output logic [1:0] grant
);
  assign grant = &elig ? (ptr ? 2'b10 : 2'b01) : elig;
endmodule

// File: rtl/map_write_arbiter.sv
// map_write_arbiter: arbitrates generator/edit writes to the map RAM and sweeps it on clear.
module map_write_arbiter
  import map_pkg::*;
#(
  parameter int                    MAP_DEPTH = 32768,
  parameter logic [BLOCK_ID_W-1:0] CLEAR_ID  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  input  logic                  gen_req,
  input  logic [MAP_ADDR_W-1:0] gen_addr,
  input  logic [BLOCK_ID_W-1:0] gen_data,
  output logic                  gen_ack,
  input  logic                  edit_req,
  input  logic [MAP_ADDR_W-1:0] edit_addr,
  input  logic [BLOCK_ID_W-1:0] edit_data,
  output logic                  edit_ack,
  output logic [MAP_ADDR_W-1:0] write_addr,
  output logic [BLOCK_ID_W-1:0] write_data,
  output logic                  write_en
);
  localparam logic [MAP_ADDR_W-1:0] LAST = MAP_ADDR_W'(MAP_DEPTH - 1);
  state_t     state, state_next;
  logic       ptr, clr_go, sweeping, sweep_end;
  logic [1:0] elig, arb_grant, grant;
  // index 0 is edit, index 1 is gen; an acked requester sits out one cycle
  assign elig = {gen_req & ~gen_ack, edit_req & ~edit_ack};
  rr_arb2 u_arb (.elig(elig), .ptr(ptr), .grant(arb_grant));
  always_comb begin
    clr_go     = state == IDLE && clear_start;
    sweep_end  = state == CLEAR && write_addr == LAST;
    sweeping   = state == CLEAR && !sweep_end;
    grant      = (state == IDLE && !clear_start) ? arb_grant : 2'b00;
    state_next = clr_go ? CLEAR : sweep_end ? IDLE : state;
  end
  assign clear_busy = state == CLEAR;
  // write_addr doubles as the sweep counter during a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      gen_ack    <= 1'b0;
      edit_ack   <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_next;
      clear_done <= sweep_end;
      gen_ack    <= grant[1];
      edit_ack   <= grant[0];
      write_en   <= clr_go | sweeping | (|grant);
      if (clr_go) begin
        write_addr <= '0;
        write_data <= CLEAR_ID;
      end else if (sweeping) begin
        write_addr <= write_addr + 1'b1;
      end else if (|grant) begin
        write_addr <= grant[1] ? gen_addr : edit_addr;
        write_data <= grant[1] ? gen_data : edit_data;
        ptr        <= grant[0];
      end
    end
  end
endmodule

// File: tb/tb_map_write_arbiter.sv
// tb_map_write_arbiter: table-driven directed checks plus clear/reset corner sequences.
module tb_map_write_arbiter;
  logic        clk, rst, clear_start, clear_busy, clear_done;
  logic        gen_req, gen_ack, edit_req, edit_ack, write_en;
  logic [14:0] gen_addr, edit_addr, write_addr;
  logic [4:0]  gen_data, edit_data, write_data;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst, cs, gr, er;
    logic [14:0] ga, ea;
    logic [4:0]  gd, ed;
    logic [24:0] exp;
  } vec_t;
  vec_t tv[$];

  map_write_arbiter #(.MAP_DEPTH(16), .CLEAR_ID(5'd0)) dut (
    .clk(clk), .rst(rst), .clear_start(clear_start), .clear_busy(clear_busy),
    .clear_done(clear_done), .gen_req(gen_req), .gen_addr(gen_addr),
    .gen_data(gen_data), .gen_ack(gen_ack), .edit_req(edit_req),
    .edit_addr(edit_addr), .edit_data(edit_data), .edit_ack(edit_ack),
    .write_addr(write_addr), .write_data(write_data), .write_en(write_en)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  always @(negedge clk) begin
    checks++;
    if (gen_ack && edit_ack) begin
      errors++;
      $display("FAIL dual_ack: gen_ack=%b edit_ack=%b required not both 1", gen_ack, edit_ack);
    end
  end

  function automatic logic [24:0] o(input logic we, input logic [14:0] wa, input logic [4:0] wd,
                                    input logic ga, input logic ea, input logic b, input logic d);
    return {we, wa, wd, ga, ea, b, d};
  endfunction

  function automatic vec_t mk(input logic r, input logic cs, input logic gr, input logic [14:0] ga,
                              input logic [4:0] gd, input logic er, input logic [14:0] ea,
                              input logic [4:0] ed, input logic [24:0] exp);
    vec_t v;
    v.rst = r; v.cs = cs; v.gr = gr; v.ga = ga; v.gd = gd;
    v.er = er; v.ea = ea; v.ed = ed; v.exp = exp;
    return v;
  endfunction

  function automatic logic [24:0] obs();
    return {write_en, write_addr, write_data, gen_ack, edit_ack, clear_busy, clear_done};
  endfunction

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {we,addr,data,gack,eack,busy,done}=%b_%h_%h_%b%b%b%b required %b_%h_%h_%b%b%b%b",
               name, act[24], act[23:9], act[8:4], act[3], act[2], act[1], act[0],
               exp[24], exp[23:9], exp[8:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; clear_start = v.cs; gen_req = v.gr; gen_addr = v.ga; gen_data = v.gd;
    edit_req = v.er; edit_addr = v.ea; edit_data = v.ed;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    rst = 1; clear_start = 0; gen_req = 0; edit_req = 0;
    gen_addr = 0; gen_data = 0; edit_addr = 0; edit_data = 0;
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0)));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 'h0123, 7, o(1, 'h0123, 7, 0, 1, 0, 0)));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 'h0123, 7, o(0, 'h0123, 7, 0, 0, 0, 0)));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, o(0, 'h0123, 7, 0, 0, 0, 0)));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0)));
    for (int i = 0; i < 6; i++)
      tv.push_back(mk(0, 0, 1, 'h0AAA, 3, 1, 'h1555, 9,
                      i % 2 == 0 ? o(1, 'h1555, 9, 0, 1, 0, 0) : o(1, 'h0AAA, 3, 1, 0, 0, 0)));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, o(0, 'h0AAA, 3, 0, 0, 0, 0)));
    tv.push_back(mk(0, 0, 1, 'h7FFF, 31, 0, 0, 0, o(1, 'h7FFF, 31, 1, 0, 0, 0)));
    tv.push_back(mk(0, 0, 1, 'h7FFF, 31, 0, 0, 0, o(0, 'h7FFF, 31, 0, 0, 0, 0)));
    tv.push_back(mk(0, 0, 1, 'h7FFF, 31, 0, 0, 0, o(1, 'h7FFF, 31, 1, 0, 0, 0)));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, o(0, 'h7FFF, 31, 0, 0, 0, 0)));
    tv.push_back(mk(1, 1, 1, 'h0AAA, 3, 1, 'h1555, 9, o(0, 0, 0, 0, 0, 0, 0)));
    tv.push_back(mk(0, 1, 0, 0, 0, 1, 'h0042, 5, o(1, 0, 0, 0, 0, 1, 0)));
    for (int i = 1; i < 16; i++)
      tv.push_back(mk(0, i == 3, 0, 0, 0, 1, 'h0042, 5, o(1, 15'(i), 0, 0, 0, 1, 0)));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 'h0042, 5, o(0, 'h000F, 0, 0, 0, 0, 1)));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 'h0042, 5, o(1, 'h0042, 5, 0, 1, 0, 0)));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, o(0, 'h0042, 5, 0, 0, 0, 0)));
    foreach (tv[i]) begin
      apply(tv[i]);
      check($sformatf("vec%0d", i), obs(), tv[i].exp);
    end

    // gen held throughout a clear
    @(negedge clk); clear_start = 1;
    @(negedge clk); clear_start = 0; gen_req = 1; gen_addr = 'h0300; gen_data = 12;
    seen = 0;
    for (int i = 0; i < 40 && !clear_done; i++) begin
      @(posedge clk); #1;
      checks++;
      if (clear_busy && gen_ack) begin
        errors++;
        $display("FAIL gen_during_clear: gen_ack=1 while clear_busy=1 required gen_ack=0");
      end
      seen = clear_done;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL clear_done_timeout: clear_done=0 after 40 cycles required 1");
    end
    @(posedge clk); #1;
    check("gen_after_clear", obs(), o(1, 'h0300, 12, 1, 0, 0, 0));
    @(negedge clk); gen_req = 0;

    // reset in the middle of a sweep
    @(negedge clk); clear_start = 1;
    @(negedge clk); clear_start = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = clear_busy && write_addr == 5;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL sweep_addr5_timeout: sweep never reached address 5 required reach");
    end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    check("rst_mid_clear", obs(), o(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); rst = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      seen |= clear_done | clear_busy;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL no_done_after_abort: clear_done/clear_busy=1 after reset required 0");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/map_write_arbiter.md
MAP_WRITE_ARBITER -- requirements
Module: map_write_arbiter

Interface
REQ-001 SHALL have parameter MAP_DEPTH, default 32768: number of map RAM entries swept by a clear.
REQ-002 SHALL have parameter CLEAR_ID, default 0: block ID written during a clear.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port clear_start, input, 1: one-cycle request to fill the whole map with CLEAR_ID.
REQ-006 SHALL have port clear_busy, output, 1: high while a clear sweep is in progress.
REQ-007 SHALL have port clear_done, output, 1: one-cycle pulse after the last clear write.
REQ-008 SHALL have ports gen_req (input, 1), gen_addr (input, 15), gen_data (input, 5) and gen_ack (output, 1): terrain-generator write requester.
REQ-009 SHALL have ports edit_req (input, 1), edit_addr (input, 15), edit_data (input, 5) and edit_ack (output, 1): player place/break write requester.
REQ-010 SHALL have ports write_addr (output, 15), write_data (output, 5) and write_en (output, 1): map RAM write port.

Function
REQ-011 SHALL implement states IDLE and CLEAR.
REQ-012 IDLE -> CLEAR SHALL occur when clear_start=1; CLEAR -> IDLE SHALL occur on the cycle after the write to address MAP_DEPTH-1.
REQ-013 In CLEAR, write_en SHALL be 1 every cycle, with write_addr counting 0..MAP_DEPTH-1 and write_data=CLEAR_ID; no ack SHALL be issued.
REQ-014 clear_busy SHALL be 1 exactly during the CLEAR-state cycles; clear_done SHALL pulse one cycle, registered, on the first IDLE cycle after the sweep.
REQ-015 clear_start SHALL be ignored while in CLEAR; in IDLE it SHALL take priority over any same-cycle request, and no grant SHALL be made that cycle.
REQ-016 A requester is eligible when its req=1 and its ack is 0 in the current cycle; a request held during its ack cycle SHALL NOT be granted twice.
REQ-017 With one eligible requester, that requester SHALL be granted.
REQ-018 With both requesters eligible, the requester not granted most recently SHALL win (round-robin); after reset, edit SHALL win the first tie.
REQ-019 A grant sampled at edge N SHALL produce, registered at edge N: write_en=1, write_addr/write_data = the winner's addr/data, and the winner's ack=1, all for exactly one cycle.
REQ-020 Every write_en cycle SHALL carry at most one ack; gen_ack and edit_ack SHALL never both be 1.
REQ-021 With no grant and not in CLEAR, write_en SHALL be 0, and write_addr/write_data SHALL hold their last values.
REQ-022 Requesters SHALL hold addr/data stable while req=1 until ack; the block SHALL NOT buffer more than the one current grant.
REQ-023 Peak throughput: one write per cycle with both requesters active; one write per two cycles with a single requester.

Reset
REQ-024 rst=1 SHALL force state=IDLE, sweep counter=0, write_en=0, write_addr=0, write_data=0, gen_ack=0, edit_ack=0, clear_busy=0, clear_done=0, and the round-robin pointer to favour edit.
REQ-025 rst asserted mid-clear SHALL abort the sweep with no clear_done pulse; rst SHALL override clear_start and all requests.

Structure
REQ-026 Package map_pkg SHALL hold MAP_ADDR_W=15, BLOCK_ID_W=5 and the state enum {IDLE, CLEAR}.
REQ-027 The two-input round-robin selector SHALL be a sub-module named rr_arb2 (inputs: eligible vector, pointer; output: one-hot grant).
REQ-028 The RTL SHALL contain no memories; the map RAM stays external.

Verification
REQ-029 Scenario: edit_req=1, addr=0x0123, data=7, held until ack -> write_en, write_addr=0x0123, write_data=7 and edit_ack all 1 for one cycle, one cycle after the request is sampled; no second write.
REQ-030 Scenario: gen_req and edit_req both held for 6 cycles -> writes alternate edit, gen, edit, gen, ... starting with edit after reset; never two acks in one cycle.
REQ-031 Scenario: clear_start pulse with MAP_DEPTH=16 -> 16 consecutive writes, addresses 0..15, data 0; clear_busy high for those 16 cycles; clear_done pulses the following cycle.
REQ-032 Scenario: gen_req held throughout a clear -> no gen_ack during clear_busy; gen granted on the first IDLE cycle.
REQ-033 Scenario: rst asserted at sweep address 5 -> the next cycle has all outputs 0; no clear_done pulse.
REQ-034 Scenario: clear_start in the same cycle as edit_req -> the clear starts at address 0; the edit is granted only after the sweep ends.
